// File: rtl/key_debounce.sv
// key_debounce: synchronises, debounces and auto-repeats three active-low
// push-buttons. The outputs are clean, registered, active-low levels. While a
// button is held, all outputs are periodically forced "released" for a short
// gap so that a downstream press detector fires again.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int GAP_CYCLES      = 2,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int CNT_W           = 25
) (
    input  logic clk_in,
    input  logic reset,
    input  logic KEY3_raw,
    input  logic KEY2_raw,
    input  logic KEY1_raw,
    output logic KEY3,
    output logic KEY2,
    output logic KEY1,
    output logic repeat_active
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;
    localparam logic [1:0] S_REPEAT = 2'd3;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    // Bit 2 = KEY3, bit 1 = KEY2, bit 0 = KEY1 throughout.
    logic [2:0]       raw;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       stable;
    logic [CNT_W-1:0] db_cnt [3];

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] rcnt;
    logic [CNT_W-1:0] rcnt_next;
    logic             pend;
    logic             pend_next;
    logic [2:0]       pressed;
    logic [2:0]       prev_pressed;
    logic             any_pressed;
    logic             new_press;
    logic             gap_force;
    logic [2:0]       keys;

    assign raw = {KEY3_raw, KEY2_raw, KEY1_raw};

    // Two-flop synchroniser per key, idling at "released".
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Per-key debounce: accept a new level after DEBOUNCE_CYCLES differing samples.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            stable <= '1;
            for (int unsigned i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (db_cnt[i] >= DB_LAST) begin
                        stable[i] <= sync2[i];
                        db_cnt[i] <= '0;
                    end else if (db_cnt[i] != '1) begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign pressed     = ~stable;
    assign any_pressed = |pressed;
    assign new_press   = |(pressed & ~prev_pressed);

    // Repeat FSM next-state logic; a full release overrides every state.
    always_comb begin
        state_next = state;
        rcnt_next  = rcnt;
        pend_next  = pend;
        case (state)
            S_IDLE: begin
                if (any_pressed) begin
                    state_next = S_HOLD;
                    rcnt_next  = '0;
                end
            end
            S_HOLD: begin
                if (new_press) begin
                    rcnt_next = '0;
                end else if (rcnt >= RD_LAST) begin
                    if (REPEAT_EN) begin
                        state_next = S_GAP;
                        rcnt_next  = '0;
                    end
                end else begin
                    rcnt_next = rcnt + 1'b1;
                end
            end
            S_GAP: begin
                pend_next = pend | new_press;
                if (rcnt >= GAP_LAST) begin
                    rcnt_next  = '0;
                    pend_next  = 1'b0;
                    state_next = (pend | new_press) ? S_HOLD : S_REPEAT;
                end else begin
                    rcnt_next = rcnt + 1'b1;
                end
            end
            default: begin
                if (new_press) begin
                    state_next = S_HOLD;
                    rcnt_next  = '0;
                end else if (rcnt >= RP_LAST) begin
                    state_next = S_GAP;
                    rcnt_next  = '0;
                end else if (rcnt != '1) begin
                    rcnt_next = rcnt + 1'b1;
                end
            end
        endcase
        if (!any_pressed) begin
            state_next = S_IDLE;
            rcnt_next  = '0;
            pend_next  = 1'b0;
        end
    end

    // Gap forcing follows the state being entered so it lines up with the
    // output register, which samples the same stable levels the FSM sees.
    assign gap_force = (state_next == S_GAP);

    // FSM state and repeat counter registers.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            rcnt         <= '0;
            pend         <= 1'b0;
            prev_pressed <= '0;
        end else begin
            state        <= state_next;
            rcnt         <= rcnt_next;
            pend         <= pend_next;
            prev_pressed <= pressed;
        end
    end

    // Registered outputs: stable levels, all forced released during a gap.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            keys          <= '1;
            repeat_active <= 1'b0;
        end else begin
            keys          <= stable | {3{gap_force}};
            repeat_active <= (state_next == S_GAP) || (state_next == S_REPEAT);
        end
    end

    assign KEY3 = keys[2];
    assign KEY2 = keys[1];
    assign KEY1 = keys[0];

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed and random stimulus against a timeline model of
// debounce windows and the repeat schedule (two DUTs: repeat on and off).
module tb_key_debounce;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 10;
    localparam int GC = 2;
    localparam int HMAX = 16384;

    logic clk_in = 1'b0;
    logic reset  = 1'b0;
    logic [2:0] raw = 3'b111;
    logic k3_a, k2_a, k1_a, ra_a;
    logic k3_b, k2_b, k1_b, ra_b;

    int total = 0;
    int bad   = 0;

    key_debounce #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                   .GAP_CYCLES(GC), .REPEAT_EN(1'b1), .CNT_W(8)) dut (
        .clk_in(clk_in), .reset(reset),
        .KEY3_raw(raw[2]), .KEY2_raw(raw[1]), .KEY1_raw(raw[0]),
        .KEY3(k3_a), .KEY2(k2_a), .KEY1(k1_a), .repeat_active(ra_a));

    key_debounce #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                   .GAP_CYCLES(GC), .REPEAT_EN(1'b0), .CNT_W(8)) dut_nr (
        .clk_in(clk_in), .reset(reset),
        .KEY3_raw(raw[2]), .KEY2_raw(raw[1]), .KEY1_raw(raw[0]),
        .KEY3(k3_b), .KEY2(k2_b), .KEY1(k1_b), .repeat_active(ra_b));

    always #5 clk_in = ~clk_in;

    // Reference model state: raw history per edge since reset, accepted
    // levels, and per-instance repeat schedule anchored at the (re)start edge.
    int         e;
    logic [2:0] rawh [HMAX];
    logic [2:0] mstable;
    bit         active [2];
    bit         pending [2];
    int         anchor [2];
    logic [2:0] prevp [2];
    bit         gapf [2];
    bit         raf [2];
    logic [2:0] ek [2];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (edge %0d, t=%0t)", tag, got, exp, e, $time);
        end
    endtask

    function automatic bit gap_at(input int n, input int k);
        if (n != 0 || k < RD) return 1'b0;
        return ((k - RD) % (GC + RP)) < GC;
    endfunction

    // Synchronised sample seen by the debouncer at edge x (reset value before).
    function automatic logic sync_at(input int x, input int i);
        if (x < 3) return 1'b1;
        return rawh[(x - 2) % HMAX][i];
    endfunction

    task automatic model_reset();
        e = 0;
        mstable = 3'b111;
        for (int n = 0; n < 2; n++) begin
            active[n] = 0; pending[n] = 0; anchor[n] = 0;
            prevp[n] = 3'b000; gapf[n] = 0; raf[n] = 0; ek[n] = 3'b111;
        end
    endtask

    task automatic model_step(input logic [2:0] r);
        logic [2:0] p;
        bit flip;
        e++;
        rawh[e % HMAX] = r;
        p = ~mstable;
        for (int n = 0; n < 2; n++) begin
            if (p == 3'b000) begin
                active[n] = 0; pending[n] = 0;
            end else if (!active[n]) begin
                active[n] = 1; anchor[n] = e; pending[n] = 0;
            end else if (pending[n]) begin
                if (!gap_at(n, e - anchor[n])) begin
                    anchor[n] = e; pending[n] = 0;
                end
            end else if ((p & ~prevp[n]) != 3'b000) begin
                if (gapf[n] && gap_at(n, e - anchor[n])) pending[n] = 1;
                else anchor[n] = e;
            end
            prevp[n] = p;
            gapf[n] = active[n] && gap_at(n, e - anchor[n]);
            raf[n]  = active[n] && (n == 0) && ((e - anchor[n]) >= RD);
            ek[n]   = mstable | {3{gapf[n]}};
        end
        for (int i = 0; i < 3; i++) begin
            flip = 1'b1;
            for (int j = 0; j < DB; j++)
                if (sync_at(e - j, i) == mstable[i]) flip = 1'b0;
            if (flip) mstable[i] = ~mstable[i];
        end
    endtask

    task automatic check_outputs();
        chk("keys_rep", int'({k3_a, k2_a, k1_a}), int'(ek[0]));
        chk("ra_rep",   int'(ra_a), int'(raf[0]));
        chk("keys_norep", int'({k3_b, k2_b, k1_b}), int'(ek[1]));
        chk("ra_norep", int'(ra_b), int'(raf[1]));
    endtask

    task automatic cyc(input logic [2:0] r);
        raw = r;
        @(posedge clk_in);
        model_step(r);
        #1;
        check_outputs();
    endtask

    task automatic async_reset_pulse();
        reset = 1'b1;
        #1;
        chk("rst_keys_rep",   int'({k3_a, k2_a, k1_a}), 7);
        chk("rst_ra_rep",     int'(ra_a), 0);
        chk("rst_keys_norep", int'({k3_b, k2_b, k1_b}), 7);
        chk("rst_ra_norep",   int'(ra_b), 0);
        @(posedge clk_in);
        #2;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int lat;
        bit found;
        model_reset();

        // Reset with all raw keys pressed; outputs released immediately.
        raw = 3'b000;
        #2;
        async_reset_pulse();

        // KEY3 held: first low output exactly DB+3 edges after reset release.
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            cyc(3'b011);
            if (lat == 0 && k3_a == 1'b0) lat = c;
        end
        chk("key3_latency", lat, DB + 3);
        // Release during repeat.
        for (int c = 0; c < 40; c++) cyc(3'b111);

        // Short KEY2 glitch, then a bounced press.
        for (int c = 0; c < 3; c++) cyc(3'b101);
        for (int c = 0; c < 12; c++) cyc(3'b111);
        cyc(3'b101); cyc(3'b111);
        for (int c = 0; c < 40; c++) cyc(3'b101);
        for (int c = 0; c < 15; c++) cyc(3'b111);

        // KEY3 held, KEY2 added so its output falls about 15 cycles later.
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            cyc(3'b011);
            if (k3_a == 1'b0) found = 1;
        end
        chk("key3_low_seen", int'(found), 1);
        for (int c = 0; c < 8; c++) cyc(3'b011);
        for (int c = 0; c < 60; c++) cyc(3'b001);
        for (int c = 0; c < 15; c++) cyc(3'b111);

        // KEY1 held 100 cycles; then reset in the middle of a gap.
        for (int c = 0; c < 100; c++) cyc(3'b110);
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            cyc(3'b110);
            if (gapf[0]) found = 1;
        end
        chk("gap_reached", int'(found), 1);
        async_reset_pulse();
        for (int c = 0; c < 40; c++) cyc(3'b110);
        for (int c = 0; c < 15; c++) cyc(3'b111);

        // Random segments, including glitches shorter than the debounce window.
        for (int s = 0; s < 250; s++) begin
            logic [2:0] r;
            int len;
            r = 3'($urandom_range(0, 7));
            len = (($urandom & 3) == 0) ? int'($urandom_range(1, DB)) : int'($urandom_range(1, 45));
            for (int c = 0; c < len; c++) cyc(r);
            if (s == 125) async_reset_pulse();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
